fp_round_stage: RTL and testbench
=================================

Name:
fp_round_stage

Overview:
- Pipelined rounding/packing stage directly downstream of the normalization stage in the FP add/sub datapath.
- Takes the normalized 27-bit significand (hidden, 23 fraction, G, R, S), the pre-normalization exponent, the signed normalization shift and the sign.
- Applies the exponent adjust and rounding, renormalizes on rounding carry, saturates to infinity or max-finite, and emits a packed IEEE-754 single plus exception flags.
- Two-stage valid/ready pipeline; sits between the normalizer and the FP register-file writeback.

Parameters:
- EXP_W, 8, exponent width.
- FRAC_W, 23, stored fraction width; sig width = FRAC_W+4.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  stage can accept a beat.
- in_sign  input  1  result sign.
- in_exp  input  8  pre-normalization exponent.
- in_shift  input  8  two's-complement normalization shift, added to in_exp.
- in_sig  input  27  bit26 hidden, 25:3 fraction, 2 guard, 1 round, 0 sticky.
- in_rm  input  3  RISC-V rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_result  output  32  packed single.
- out_flags  output  3  {overflow, underflow, inexact}.

Behaviour:
- Reset: all valid bits 0, out_result 0, out_flags 0, in_ready 1. Asynchronous assert; synchronous-style deassert to clk.
- Reset mid-operation: in-flight beats are discarded; no output appears after reset releases.
- Latency: 2 cycles from accepted beat to out_valid when not stalled. Throughput: 1 beat/cycle.
- Handshake: transfer occurs when valid && ready.
  - S2 advances when !s2_valid || out_ready.
  - S1 advances when !s1_valid || S2 advances.
  - in_ready = !s1_valid || S2 advances.
  - Outputs hold stable while out_valid && !out_ready.
  - in_ready does not depend combinationally on in_valid.
- Stage 1 (registered at end):
  - exp_adj = {2'b00, in_exp} + sign-extend(in_shift), computed at 10 bits signed.
  - lsb = sig[3]; inexact = G|R|S.
  - inc: RNE = G & (R|S|lsb); RTZ = 0; RDN = sign & inexact; RUP = !sign & inexact; RMM = G.
  - rm 101..111 is treated as RNE.
- Stage 2 (registered at end):
  - m = sig[26:3] + inc, 25 bits.
  - If m[24]: mantissa = m[24:1], exp = exp_adj + 1.
  - Else if exp_adj == 0 and m[23]: denormal rounded up to normal, exp = 1.
  - Else exp = exp_adj.
  - If exp >= 255 (unsigned, 10-bit): overflow = 1, inexact = 1.
    - Result is infinity {sign, 8'hFF, 0} under RNE, RMM, RUP(+) and RDN(-).
    - Otherwise the result is max-finite {sign, 8'hFE, 23'h7FFFFF}.
  - exp_adj negative never occurs; if it does, treat it as 0 and set underflow.
  - underflow = (final exp == 0) && inexact (tininess after rounding).
  - Zero significand with exp 0 packs to signed zero, flags 0.

Optional Feature:
- Macro FP_ROUND_ALL_MODES_EN.
- Defined: all five RISC-V rounding modes behave as specified above.
- Undefined: in_rm is ignored, the block is RNE-only, and overflow always produces infinity.

Test Plan:
- RNE tie-to-even: in_exp=8'h7F, in_shift=0, in_sig=27'h4000004, rm=000 -> out_result=32'h3F800000, flags=3'b001, out_valid 2 cycles after accept.
- RNE round-up: in_sig=27'h400000C, exp 7F, shift 0 -> 32'h3F800002, flags=001.
- Rounding carry renormalize: in_sig=27'h7FFFFFC, exp 7F, shift 0 -> 32'h40000000, flags=001.
- Overflow: in_exp=8'hFE, in_shift=8'h01, in_sig=27'h4000000, sign 0.
  - rm=000 -> 32'h7F800000, flags=101.
  - rm=001 -> 32'h7F7FFFFF with FP_ROUND_ALL_MODES_EN; 32'h7F800000 without.
- Denormal rounds to normal: in_exp=0, shift 0, in_sig=27'h3FFFFFC, rm=000 -> 32'h00800000, flags=001 (underflow 0).
- Backpressure/reset: hold out_ready=0 and push 3 beats.
  - Exactly 2 accepted, then in_ready=0 and out_result stable.
  - Release out_ready -> beats emerge in order.
  - Assert rst_n=0 mid-stream -> out_valid=0 immediately, in_ready=1.

Source files
------------

// File: rtl/fp_round_stage.sv
// Rounding/packing stage after the FP add/sub normalizer: exponent adjust, round, renormalize, saturate, pack.
// Latency 2 cycles, 1 beat/cycle; both stages stall in place when out_ready is low, and in_ready drops once both are full.
// Build option FP_ROUND_ALL_MODES_EN enables all five rounding modes; without it the stage is RNE-only.
module fp_round_stage #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sign,
  input  logic [EXP_W-1:0]      in_exp,
  input  logic [EXP_W-1:0]      in_shift,
  input  logic [FRAC_W+3:0]     in_sig,
  input  logic [2:0]            in_rm,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [EXP_W+FRAC_W:0] out_result,
  output logic [2:0]            out_flags
);

  localparam int MANT_W = FRAC_W + 1;
  localparam int XW     = EXP_W + 2;
  localparam logic [XW-1:0] EXP_ONE = {{(XW-1){1'b0}}, 1'b1};
  localparam logic [XW-1:0] EXP_SAT = {2'b00, {EXP_W{1'b1}}};

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rm_e;

  // ---------------- handshake ----------------
  logic s1_valid, s2_valid, s1_adv, s2_adv;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  // ---------------- stage 1: exponent adjust and round decision ----------------
  rm_e rm_eff;

`ifdef FP_ROUND_ALL_MODES_EN
  // Decode the rounding mode; reserved encodings fall back to RNE.
  always_comb begin
    rm_eff = RM_RNE;
    case (in_rm)
      3'd1:    rm_eff = RM_RTZ;
      3'd2:    rm_eff = RM_RDN;
      3'd3:    rm_eff = RM_RUP;
      3'd4:    rm_eff = RM_RMM;
      default: rm_eff = RM_RNE;
    endcase
  end
`else
  // RNE-only build: the mode input is ignored.
  assign rm_eff = RM_RNE;
  logic unused_rm;
  assign unused_rm = ^in_rm;
`endif

  logic                 lsb, g_bit, rs_bits, inexact_c, inc_c;
  logic signed [XW-1:0] exp_adj_c;

  assign lsb       = in_sig[3];
  assign g_bit     = in_sig[2];
  assign rs_bits   = in_sig[1] | in_sig[0];
  assign inexact_c = g_bit | rs_bits;
  assign exp_adj_c = $signed({2'b00, in_exp}) + $signed({{2{in_shift[EXP_W-1]}}, in_shift});

  // Increment decision for each rounding mode.
  always_comb begin
    inc_c = 1'b0;
    case (rm_eff)
      RM_RNE:  inc_c = g_bit & (rs_bits | lsb);
      RM_RTZ:  inc_c = 1'b0;
      RM_RDN:  inc_c = in_sign & inexact_c;
      RM_RUP:  inc_c = !in_sign & inexact_c;
      RM_RMM:  inc_c = g_bit;
      default: inc_c = g_bit & (rs_bits | lsb);
    endcase
  end

  logic                 s1_sign, s1_inc, s1_inexact;
  logic signed [XW-1:0] s1_exp_adj;
  logic [MANT_W-1:0]    s1_mant;
  rm_e                  s1_rm;

  // Stage 1 register: loads a new beat whenever it can hand its contents on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_sign    <= 1'b0;
      s1_inc     <= 1'b0;
      s1_inexact <= 1'b0;
      s1_exp_adj <= '0;
      s1_mant    <= '0;
      s1_rm      <= RM_RNE;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign    <= in_sign;
        s1_inc     <= inc_c;
        s1_inexact <= inexact_c;
        s1_exp_adj <= exp_adj_c;
        s1_mant    <= in_sig[FRAC_W+3:3];
        s1_rm      <= rm_eff;
      end
    end
  end

  // ---------------- stage 2: increment, renormalize, saturate, pack ----------------
  logic [MANT_W:0]          m;
  logic                     exp_neg;
  logic [XW-1:0]            exp_base, exp_r;
  logic [FRAC_W-1:0]        frac_r;
  logic                     ovf, to_inf;
  logic [EXP_W+FRAC_W:0]    result_c;
  logic [2:0]               flags_c;

  assign m        = {1'b0, s1_mant} + {{MANT_W{1'b0}}, s1_inc};
  assign exp_neg  = s1_exp_adj[XW-1];
  assign exp_base = exp_neg ? '0 : s1_exp_adj;

  // Renormalize on rounding carry; a subnormal that rounds into the hidden bit becomes exponent 1.
  always_comb begin
    exp_r  = exp_base;
    frac_r = m[FRAC_W-1:0];
    if (m[MANT_W]) begin
      exp_r  = exp_base + EXP_ONE;
      frac_r = m[FRAC_W:1];
    end else if ((exp_base == '0) && m[MANT_W-1]) begin
      exp_r = EXP_ONE;
    end
  end

  assign ovf = (exp_r >= EXP_SAT);

  // Overflow goes to infinity unless the mode rounds toward zero for this sign.
  always_comb begin
    to_inf = 1'b1;
    case (s1_rm)
      RM_RTZ:  to_inf = 1'b0;
      RM_RDN:  to_inf = s1_sign;
      RM_RUP:  to_inf = !s1_sign;
      default: to_inf = 1'b1;
    endcase
  end

  // Final packing and exception flags {overflow, underflow, inexact}.
  always_comb begin
    result_c = {s1_sign, exp_r[EXP_W-1:0], frac_r};
    flags_c  = {1'b0, exp_neg | ((exp_r == '0) && s1_inexact), s1_inexact};
    if (ovf) begin
      flags_c = 3'b101;
      if (to_inf) result_c = {s1_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      else        result_c = {s1_sign, {(EXP_W-1){1'b1}}, 1'b0, {FRAC_W{1'b1}}};
    end
  end

  // Stage 2 register: holds the result stable until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid   <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= result_c;
        out_flags  <= flags_c;
      end
    end
  end

endmodule

// File: tb/tb_fp_round_stage.sv
module tb_fp_round_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_sign, out_valid, out_ready;
  logic [7:0]  in_exp, in_shift;
  logic [26:0] in_sig;
  logic [2:0]  in_rm, out_flags;
  logic [31:0] out_result;

  int checks   = 0;
  int failures = 0;

  fp_round_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_shift(in_shift),
    .in_sig(in_sig), .in_rm(in_rm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sign;
    logic [7:0]  exp;
    logic [7:0]  shift;
    logic [26:0] sig;
    logic [2:0]  rm;
    logic [31:0] res;
    logic [2:0]  flags;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs[NV];

  logic [34:0] exp_q[$];
  bit          accepted_last;

  task automatic chk(input bit ok, input string what, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %h required %h", what, act, req);
    end
  endtask

  // Reference: round the 27-bit value to a 24-bit integer with plain arithmetic, then classify.
  function automatic logic [34:0] ref_model(input logic sgn, input logic [7:0] e_in,
                                            input logic [7:0] sh, input logic [26:0] sig,
                                            input logic [2:0] rm);
    int e, q, rem, mode;
    bit up, inx, ovf, unf, to_inf;
    logic [31:0] res;
    e = int'(e_in) + (sh[7] ? int'(sh) - 256 : int'(sh));
    unf = 0;
    if (e < 0) begin e = 0; unf = 1; end
    q    = int'(sig) / 8;
    rem  = int'(sig) % 8;
    inx  = (rem != 0);
    mode = int'(rm);
`ifndef FP_ROUND_ALL_MODES_EN
    mode = 0;
`endif
    if (mode > 4) mode = 0;
    case (mode)
      0:       up = (rem > 4) || (rem == 4 && (q % 2) == 1);
      1:       up = 0;
      2:       up = sgn && inx;
      3:       up = !sgn && inx;
      default: up = (rem >= 4);
    endcase
    q = q + (up ? 1 : 0);
    if (q >= 32'h100_0000) begin
      q = q / 2;
      e = e + 1;
    end else if (e == 0 && q >= 32'h80_0000) begin
      e = 1;
    end
    ovf = 0;
    if (e >= 255) begin
      ovf = 1;
      inx = 1;
      to_inf = (mode == 0) || (mode == 4) || (mode == 3 && !sgn) || (mode == 2 && sgn);
      res = to_inf ? {sgn, 8'hFF, 23'h0} : {sgn, 8'hFE, 23'h7FFFFF};
    end else begin
      res = {sgn, e[7:0], q[22:0]};
      if (e == 0 && inx) unf = 1;
    end
    return {res, ovf, unf, inx};
  endfunction

  task automatic present(input int i);
    in_valid = 1'b1;
    in_sign  = vecs[i].sign;
    in_exp   = vecs[i].exp;
    in_shift = vecs[i].shift;
    in_sig   = vecs[i].sig;
    in_rm    = vecs[i].rm;
  endtask

  // One clock of scoreboarded traffic: record accepts, compare deliveries, advance past the edge.
  task automatic sb_cycle();
    logic [34:0] e;
    #1;
    accepted_last = in_valid && in_ready;
    if (accepted_last) exp_q.push_back(ref_model(in_sign, in_exp, in_shift, in_sig, in_rm));
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk(1'b0, "unexpected_output", out_result, 32'h0);
      end else begin
        e = exp_q.pop_front();
        chk(out_result == e[34:3], "sb_result", out_result, e[34:3]);
        chk(out_flags == e[2:0], "sb_flags", {29'h0, out_flags}, {29'h0, e[2:0]});
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] r32, snap;
    int idx, seen, sh;

    vecs[0] = '{1'b0, 8'h7F, 8'h00, 27'h4000004, 3'd0, 32'h3F800000, 3'b001};
    vecs[1] = '{1'b0, 8'h7F, 8'h00, 27'h400000C, 3'd0, 32'h3F800002, 3'b001};
    vecs[2] = '{1'b0, 8'h7F, 8'h00, 27'h7FFFFFC, 3'd0, 32'h40000000, 3'b001};
    vecs[3] = '{1'b0, 8'hFE, 8'h01, 27'h4000000, 3'd0, 32'h7F800000, 3'b101};
`ifdef FP_ROUND_ALL_MODES_EN
    vecs[4] = '{1'b0, 8'hFE, 8'h01, 27'h4000000, 3'd1, 32'h7F7FFFFF, 3'b101};
`else
    vecs[4] = '{1'b0, 8'hFE, 8'h01, 27'h4000000, 3'd1, 32'h7F800000, 3'b101};
`endif
    vecs[5] = '{1'b0, 8'h00, 8'h00, 27'h3FFFFFC, 3'd0, 32'h00800000, 3'b001};
    vecs[6] = '{1'b1, 8'h00, 8'h00, 27'h0000000, 3'd0, 32'h80000000, 3'b000};
    vecs[7] = '{1'b0, 8'h01, 8'hFE, 27'h0000008, 3'd0, 32'h00000001, 3'b010};
    vecs[8] = '{1'b1, 8'h80, 8'hFF, 27'h4000008, 3'd0, 32'hBF800001, 3'b000};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_sign = 1'b0; in_exp = '0; in_shift = '0; in_sig = '0; in_rm = '0;
    accepted_last = 0;
    repeat (3) @(posedge clk);
    #1;
    chk(!out_valid, "rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk(in_ready, "rst_in_ready", {31'h0, in_ready}, 32'h1);
    chk(out_result == 32'h0, "rst_out_result", out_result, 32'h0);
    chk(out_flags == 3'b000, "rst_out_flags", {29'h0, out_flags}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors, one at a time, with a latency check on each.
    for (int i = 0; i < NV; i++) begin
      present(i);
      out_ready = 1'b1;
      #1;
      chk(in_ready, $sformatf("v%0d_in_ready", i), {31'h0, in_ready}, 32'h1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk(!out_valid, $sformatf("v%0d_lat1_valid", i), {31'h0, out_valid}, 32'h0);
      @(posedge clk);
      #1;
      chk(out_valid, $sformatf("v%0d_lat2_valid", i), {31'h0, out_valid}, 32'h1);
      chk(out_result == vecs[i].res, $sformatf("v%0d_result", i), out_result, vecs[i].res);
      chk(out_flags == vecs[i].flags, $sformatf("v%0d_flags", i), {29'h0, out_flags}, {29'h0, vecs[i].flags});
      @(posedge clk);
      #1;
    end

    // Backpressure: three beats offered with the consumer stalled.
    out_ready = 1'b0;
    idx = 0;
    accepted_last = 0;
    repeat (4) begin
      if (accepted_last) idx++;
      present(idx);
      sb_cycle();
    end
    if (accepted_last) idx++;
    chk(idx == 2, "bp_accepted", idx, 2);
    #1;
    chk(!in_ready, "bp_in_ready_low", {31'h0, in_ready}, 32'h0);
    chk(out_valid, "bp_out_valid", {31'h0, out_valid}, 32'h1);
    snap = out_result;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk(out_result == snap, "bp_hold_result", out_result, snap);
    chk(out_valid, "bp_hold_valid", {31'h0, out_valid}, 32'h1);
    // Release: the scoreboard verifies the beats emerge in order.
    out_ready = 1'b1;
    accepted_last = 0;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (accepted_last) idx++;
      if (idx < 3) present(idx);
      else in_valid = 1'b0;
      #1;
      if (out_valid) seen++;
      sb_cycle();
      if (idx >= 3 && exp_q.size() == 0) break;
    end
    chk(seen == 3, "bp_drained_count", seen, 3);

    // Reset in the middle of a stalled stream.
    out_ready = 1'b0;
    accepted_last = 0;
    present(3);
    sb_cycle();
    present(8);
    sb_cycle();
    chk(out_valid, "mid_pre_valid", {31'h0, out_valid}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk(!out_valid, "mid_rst_valid", {31'h0, out_valid}, 32'h0);
    chk(in_ready, "mid_rst_in_ready", {31'h0, in_ready}, 32'h1);
    chk(out_result == 32'h0, "mid_rst_result", out_result, 32'h0);
    exp_q.delete();
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk(!out_valid, "post_rst_no_output", {31'h0, out_valid}, 32'h0);
      sb_cycle();
    end

    // Randomized traffic against the reference model with random stalls.
    in_valid = 1'b0;
    accepted_last = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!in_valid || accepted_last) begin
        in_valid = ($urandom_range(0, 3) != 0);
        r32 = $urandom;
        in_sign = r32[31];
        in_rm = 3'($urandom_range(0, 7));
        r32 = $urandom;
        in_exp = r32[7:0];
        if ($urandom_range(0, 3) == 0) begin
          r32 = $urandom;
          in_shift = r32[7:0];
        end else begin
          sh = $urandom_range(0, 6) - 3;
          in_shift = sh[7:0];
        end
        r32 = $urandom;
        in_sig = r32[26:0];
        if ($urandom_range(0, 3) == 0) in_sig[2:0] = 3'b100;
        if ($urandom_range(0, 7) == 0) in_sig[26:3] = 24'hFFFFFF;
        if ($urandom_range(0, 7) == 0) in_exp = 8'h00;
        if ($urandom_range(0, 7) == 0) in_exp = 8'hFE;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      sb_cycle();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) sb_cycle();
    chk(exp_q.size() == 0, "final_drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
